// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef logic port_t;

  localparam int unsigned MAX_BURST_DEFAULT = 4;

  function automatic int unsigned burst_width(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

  localparam int unsigned BURST_W_DEFAULT = burst_width(MAX_BURST_DEFAULT);

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner pick: lone requester, locked burst continuation, else round-robin.
module arb_select
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT,
  parameter int unsigned BW        = BURST_W_DEFAULT
) (
  input  logic          i_p0_req,
  input  logic          i_p1_req,
  input  port_t         i_last_owner,
  input  logic          i_last_lock,
  input  logic [BW-1:0] i_burst_cnt,
  output port_t         o_winner
);

  always_comb begin
    o_winner = i_last_owner;
    if (i_p0_req && !i_p1_req) begin
      o_winner = 1'b0;
    end else if (i_p1_req && !i_p0_req) begin
      o_winner = 1'b1;
    end else if (i_last_lock && (i_burst_cnt < BW'(MAX_BURST))) begin
      o_winner = i_last_owner;
    end else begin
      o_winner = ~i_last_owner;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter serialising core and loader accesses onto one single-port memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AWIDTH    = 5,
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [AWIDTH-1:0] p0_addr,
  input  logic [DWIDTH-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [AWIDTH-1:0] p1_addr,
  input  logic [DWIDTH-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DWIDTH-1:0] rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned BW = burst_width(MAX_BURST);

  state_t            r_state;
  state_t            w_next;
  port_t             r_owner;
  port_t             w_win;
  logic              r_lock;
  logic [BW-1:0]     r_burst;
  logic              r_we;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;
  logic [DWIDTH-1:0] r_rdata;
  logic              r_rvalid;
  logic              w_any_req;
  logic              w_take;

  assign w_any_req = p0_req | p1_req;
  assign w_take    = (r_state == IDLE) && w_any_req;

  arb_select #(
    .MAX_BURST (MAX_BURST),
    .BW        (BW)
  ) u_select (
    .i_p0_req     (p0_req),
    .i_p1_req     (p1_req),
    .i_last_owner (r_owner),
    .i_last_lock  (r_lock),
    .i_burst_cnt  (r_burst),
    .o_winner     (w_win)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = ACCESS;
      ACCESS:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Owner changes only at the end of an arbitration cycle, so during the
  // rvalid cycle r_owner still names the port whose read just completed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner  <= 1'b1;
      r_lock   <= 1'b0;
      r_burst  <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      if (w_take) begin
        r_owner <= w_win;
        r_lock  <= w_win ? p1_lock  : p0_lock;
        r_we    <= w_win ? p1_we    : p0_we;
        r_addr  <= w_win ? p1_addr  : p0_addr;
        r_wdata <= w_win ? p1_wdata : p0_wdata;
        if (w_win != r_owner) begin
          r_burst <= BW'(1);
        end else if (r_burst < BW'(MAX_BURST)) begin
          r_burst <= r_burst + 1'b1;
        end
      end
      if ((r_state == ACCESS) && !r_we) begin
        r_rdata  <= mem_rdata;
        r_rvalid <= 1'b1;
      end
    end
  end

  always_comb begin
    busy      = (r_state == ACCESS);
    mem_rd    = busy & ~r_we;
    mem_wr    = busy & r_we;
    p0_gnt    = busy & ~r_owner;
    p1_gnt    = busy & r_owner;
    p0_rvalid = r_rvalid & ~r_owner;
    p1_rvalid = r_rvalid & r_owner;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    rdata     = r_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed commands, expected grants/read data queued, monitor compares.
module tb_mem_arbiter;

  logic       clk;
  logic       rst;
  logic       p0_req, p0_we, p0_lock;
  logic [4:0] p0_addr;
  logic [7:0] p0_wdata;
  logic       p1_req, p1_we, p1_lock;
  logic [4:0] p1_addr;
  logic [7:0] p1_wdata;
  logic       p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [7:0] rdata;
  logic       mem_rd, mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;

  logic [7:0] mem [32];

  typedef struct { bit we; bit lock; logic [4:0] addr; logic [7:0] wdata; } cmd_t;
  typedef struct { bit port; bit we; logic [4:0] addr; logic [7:0] wdata; } gexp_t;
  typedef struct { bit port; logic [7:0] data; } rexp_t;

  cmd_t  q0[$];
  cmd_t  q1[$];
  gexp_t gq[$];
  rexp_t rq[$];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .AWIDTH    (5),
    .DWIDTH    (8),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_lock   (p0_lock),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_lock   (p1_lock),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p0_gnt    (p0_gnt),
    .p1_gnt    (p1_gnt),
    .p0_rvalid (p0_rvalid),
    .p1_rvalid (p1_rvalid),
    .rdata     (rdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write committed at the clock edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr === 1'b1) mem[mem_addr] <= mem_wdata;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void q_cmd(input bit port, input bit we, input bit lock,
                                input logic [4:0] addr, input logic [7:0] wdata);
    cmd_t c;
    c.we = we; c.lock = lock; c.addr = addr; c.wdata = wdata;
    if (port) q1.push_back(c);
    else      q0.push_back(c);
  endfunction

  function automatic void push_g(input bit port, input bit we, input logic [4:0] addr,
                                 input logic [7:0] wdata);
    gexp_t g;
    g.port = port; g.we = we; g.addr = addr; g.wdata = wdata;
    gq.push_back(g);
  endfunction

  function automatic void push_r(input bit port, input logic [7:0] data);
    rexp_t r;
    r.port = port; r.data = data;
    rq.push_back(r);
  endfunction

  task automatic serve(input bit port);
    cmd_t c;
    int unsigned n;
    while (port ? (q1.size() > 0) : (q0.size() > 0)) begin
      if (port) begin
        c = q1.pop_front();
        p1_req = 1'b1; p1_we = c.we; p1_lock = c.lock; p1_addr = c.addr; p1_wdata = c.wdata;
      end else begin
        c = q0.pop_front();
        p0_req = 1'b1; p0_we = c.we; p0_lock = c.lock; p0_addr = c.addr; p0_wdata = c.wdata;
      end
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!((port ? p1_gnt : p0_gnt) === 1'b1) && n < 40);
      if (!((port ? p1_gnt : p0_gnt) === 1'b1)) chk("gnt_timeout", 32'(port), 32'(port + 2));
      @(posedge clk);
      #1;
      if (port) p1_req = 1'b0;
      else      p0_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Monitor: pops expected grants/read data whenever the DUT strobes them.
  bit prev_rd_gnt = 1'b0;
  bit prev_port   = 1'b0;
  initial begin
    gexp_t g;
    rexp_t r;
    bit    e0, e1;
    forever begin
      @(negedge clk);
      e0 = prev_rd_gnt && !prev_port && (rst === 1'b1);
      e1 = prev_rd_gnt &&  prev_port && (rst === 1'b1);
      if (p0_rvalid === 1'b1 || p1_rvalid === 1'b1 || e0 || e1)
        chk("rvalid_timing", 32'({p1_rvalid, p0_rvalid}), 32'({e1, e0}));
      if (p0_gnt === 1'b1 && p1_gnt === 1'b1) chk("dual_gnt", 32'd1, 32'd0);
      if (p0_gnt === 1'b1 || p1_gnt === 1'b1) begin
        if (gq.size() == 0) begin
          chk("unexpected_gnt", 32'({p1_gnt, p0_gnt}), 32'd0);
        end else begin
          g = gq.pop_front();
          chk("gnt_port", 32'(p1_gnt), 32'(g.port));
          chk("gnt_cmd",
              32'({busy, mem_rd, mem_wr, mem_addr, (g.we ? mem_wdata : 8'h00)}),
              32'({1'b1, ~g.we, g.we, g.addr, (g.we ? g.wdata : 8'h00)}));
        end
      end
      if (p0_rvalid === 1'b1 || p1_rvalid === 1'b1) begin
        if (rq.size() == 0) begin
          chk("unexpected_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
        end else begin
          r = rq.pop_front();
          chk("rvalid_port", 32'(p1_rvalid), 32'(r.port));
          chk("rdata", 32'(rdata), 32'(r.data));
        end
      end
      prev_rd_gnt = ((p0_gnt === 1'b1) || (p1_gnt === 1'b1)) && (mem_rd === 1'b1);
      prev_port   = (p1_gnt === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    for (int i = 0; i < 32; i++) mem[i] = 8'h10 + 8'(i);
    mem[3] = 8'hA5;
    rst = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_lock = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_lock = 1'b0; p1_addr = '0; p1_wdata = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_strobes", 32'({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_rd, mem_wr, busy}), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);

    // Single p0 read of addr 3 with exact cycle timing
    do_reset();
    push_g(1'b0, 1'b0, 5'h03, 8'h00);
    push_r(1'b0, 8'hA5);
    p0_req = 1'b1; p0_we = 1'b0; p0_lock = 1'b0; p0_addr = 5'h03;
    @(negedge clk);
    chk("t1_idle", 32'({p0_gnt, busy}), 32'd0);
    @(posedge clk); #1 p0_req = 1'b0;
    @(negedge clk);
    chk("t1_gnt", 32'({p0_gnt, mem_rd, mem_addr}), 32'({1'b1, 1'b1, 5'h03}));
    chk("t1_p1_quiet", 32'({p1_gnt, p1_rvalid}), 32'd0);
    @(negedge clk);
    chk("t1_rvalid", 32'({p0_rvalid, rdata}), 32'({1'b1, 8'hA5}));
    chk("t1_p1_quiet2", 32'({p1_gnt, p1_rvalid}), 32'd0);
    repeat (2) @(posedge clk);

    // Both requesting, no lock: alternate starting with p0
    do_reset();
    q_cmd(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    q_cmd(1'b0, 1'b0, 1'b0, 5'h01, 8'h00);
    q_cmd(1'b1, 1'b0, 1'b0, 5'h02, 8'h00);
    q_cmd(1'b1, 1'b0, 1'b0, 5'h04, 8'h00);
    push_g(1'b0, 1'b0, 5'h00, 8'h00); push_r(1'b0, 8'h10);
    push_g(1'b1, 1'b0, 5'h02, 8'h00); push_r(1'b1, 8'h12);
    push_g(1'b0, 1'b0, 5'h01, 8'h00); push_r(1'b0, 8'h11);
    push_g(1'b1, 1'b0, 5'h04, 8'h00); push_r(1'b1, 8'h14);
    fork serve(1'b0); serve(1'b1); join
    repeat (3) @(posedge clk);

    // p1 locked burst against continuous p0 requests
    do_reset();
    q_cmd(1'b0, 1'b0, 1'b0, 5'h05, 8'h00);
    q_cmd(1'b0, 1'b0, 1'b0, 5'h06, 8'h00);
    q_cmd(1'b0, 1'b0, 1'b0, 5'h07, 8'h00);
    q_cmd(1'b1, 1'b1, 1'b1, 5'h08, 8'hC0);
    q_cmd(1'b1, 1'b1, 1'b1, 5'h09, 8'hC1);
    q_cmd(1'b1, 1'b1, 1'b1, 5'h0A, 8'hC2);
    q_cmd(1'b1, 1'b1, 1'b1, 5'h0B, 8'hC3);
    q_cmd(1'b1, 1'b1, 1'b1, 5'h0C, 8'hC4);
    push_g(1'b0, 1'b0, 5'h05, 8'h00); push_r(1'b0, 8'h15);
    push_g(1'b1, 1'b1, 5'h08, 8'hC0);
    push_g(1'b1, 1'b1, 5'h09, 8'hC1);
    push_g(1'b1, 1'b1, 5'h0A, 8'hC2);
    push_g(1'b1, 1'b1, 5'h0B, 8'hC3);
    push_g(1'b0, 1'b0, 5'h06, 8'h00); push_r(1'b0, 8'h16);
    push_g(1'b1, 1'b1, 5'h0C, 8'hC4);
    push_g(1'b0, 1'b0, 5'h07, 8'h00); push_r(1'b0, 8'h17);
    fork serve(1'b0); serve(1'b1); join
    repeat (3) @(posedge clk);
    chk("t3_mem_0b", 32'(mem[5'h0B]), 32'h0C3);

    // p1 writes top address, p0 reads it back
    q_cmd(1'b1, 1'b1, 1'b0, 5'h1F, 8'h3C);
    push_g(1'b1, 1'b1, 5'h1F, 8'h3C);
    serve(1'b1);
    q_cmd(1'b0, 1'b0, 1'b0, 5'h1F, 8'h00);
    push_g(1'b0, 1'b0, 5'h1F, 8'h00); push_r(1'b0, 8'h3C);
    serve(1'b0);
    repeat (3) @(posedge clk);

    // Reset asserted during a p0 write access
    push_g(1'b0, 1'b1, 5'h10, 8'h77);
    @(posedge clk); #1;
    p0_req = 1'b1; p0_we = 1'b1; p0_lock = 1'b0; p0_addr = 5'h10; p0_wdata = 8'h77;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (p0_gnt !== 1'b1 && n < 10);
    chk("t5_gnt_seen", 32'(p0_gnt), 32'd1);
    #1 rst = 1'b0; p0_req = 1'b0; p0_we = 1'b0;
    @(negedge clk);
    chk("t5_mem_commit", 32'(mem[5'h10]), 32'h77);
    chk("t5_after_rst", 32'({p0_rvalid, p0_gnt, busy}), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    q_cmd(1'b0, 1'b0, 1'b0, 5'h10, 8'h00);
    q_cmd(1'b1, 1'b0, 1'b0, 5'h11, 8'h00);
    push_g(1'b0, 1'b0, 5'h10, 8'h00); push_r(1'b0, 8'h77);
    push_g(1'b1, 1'b0, 5'h11, 8'h00); push_r(1'b1, 8'h21);
    fork serve(1'b0); serve(1'b1); join
    repeat (3) @(posedge clk);

    // p0 withdraws before being sampled while p1 requests
    push_g(1'b1, 1'b0, 5'h03, 8'h00); push_r(1'b1, 8'hA5);
    #1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 5'h01;
    p1_req = 1'b1; p1_we = 1'b0; p1_lock = 1'b0; p1_addr = 5'h03;
    @(negedge clk);
    p0_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (p1_gnt !== 1'b1 && n < 10);
    chk("t6_p1_gnt", 32'({p1_gnt, p0_gnt}), 32'b10);
    @(posedge clk); #1 p1_req = 1'b0;
    repeat (4) @(posedge clk);

    chk("gnt_queue_empty", 32'(gq.size()), 32'd0);
    chk("rvalid_queue_empty", 32'(rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
